conv_window_sched: RTL and testbench

Sequencer for the 3x3 `conv_unit` MAC datapath.
- Loads the nine kernel weights serially, accepts a raster-order pixel stream and builds sliding 3x3 windows from two line buffers.
- Presents each valid window plus the held weights to `conv_unit` and tags the returned result with its output coordinates.
- Sits between the feature-map fetch logic and the result writer.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/line_buffer.sv | 32 +++
 rtl/conv_window_sched.sv | 175 +++++++++++++++++
 tb/tb_conv_window_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window scheduler.
package conv_pkg;

  // Default pixel/weight width; results are twice this wide.
  localparam int DEF_WIDTH = 9;

  // Number of kernel taps.
  localparam int N_TAPS = 9;

  // Weight register index for each conv_unit weight port, in load order.
  localparam int B00 = 0;
  localparam int B01 = 1;
  localparam int B02 = 2;
  localparam int B10 = 3;
  localparam int B11 = 4;
  localparam int B12 = 5;
  localparam int B20 = 6;
  localparam int B21 = 7;
  localparam int B22 = 8;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// Two-row line buffer. One address selects a column. A write pushes the new
// pixel into the middle row and moves the old middle-row pixel into the top
// row. Both rows are read at the same column in the same cycle.
module line_buffer #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 8,
  localparam int AW   = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] row_top,
  output logic [WIDTH-1:0] row_mid
);

  logic [WIDTH-1:0] mem_top [IMG_W];
  logic [WIDTH-1:0] mem_mid [IMG_W];

  // Shift the column vertically: the middle row moves to the top row and the new pixel lands in the middle row.
  // NOTE: storage has no reset; every entry is written before a valid window reads it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_mid[addr] <= wdata;
      mem_top[addr] <= mem_mid[addr];
    end
  end

  assign row_top = mem_top[addr];
  assign row_mid = mem_mid[addr];

endmodule

// File: rtl/conv_window_sched.sv
// Sequencer for the 3x3 conv_unit. It loads the kernel weights, builds
// sliding windows from a raster pixel stream and tags each conv_unit result
// with the top-left coordinate of its window.
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8,
  parameter int CONV_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       w_valid,
  input  logic [WIDTH-1:0]           w_data,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [WIDTH-1:0]           pix_data,
  output logic [WIDTH-1:0]           a00, a01, a02, a10, a11, a12, a20, a21, a22,
  output logic [WIDTH-1:0]           b00, b01, b02, b10, b11, b12, b20, b21, b22,
  input  logic [2*WIDTH-1:0]         conv_out,
  output logic                       res_valid,
  output logic [2*WIDTH-1:0]         res_data,
  output logic [$clog2(IMG_H)-1:0]   res_row,
  output logic [$clog2(IMG_W)-1:0]   res_col,
  output logic                       busy,
  output logic                       done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int DW = $clog2(CONV_LAT + 2);

  state_t           state, state_nxt;
  logic [RW-1:0]    row;
  logic [CW-1:0]    col;
  logic [3:0]       w_idx;
  logic [DW-1:0]    drain_cnt;
  logic [WIDTH-1:0] win [3][3];
  logic [WIDTH-1:0] wgt [N_TAPS];
  logic [WIDTH-1:0] lb_top, lb_mid;
  logic             accept, last_pix, win_ok;

  // Tag pipe: stage 0 is loaded on the accepting edge, stage CONV_LAT lines up with conv_out.
  logic [CONV_LAT:0] tag_vld;
  logic [RW-1:0]     tag_row [CONV_LAT+1];
  logic [CW-1:0]     tag_col [CONV_LAT+1];

  assign accept   = pix_valid && pix_ready;
  assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
  assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));

  line_buffer #(.WIDTH(WIDTH), .IMG_W(IMG_W)) u_line_buffer (
    .clk     (clk),
    .we      (accept),
    .addr    (col),
    .wdata   (pix_data),
    .row_top (lb_top),
    .row_mid (lb_mid)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  // NOTE: assign a default before the case so that no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LOAD_W;
      ST_LOAD_W: if (w_valid && (w_idx == 4'(B22))) state_nxt = ST_STREAM;
      ST_STREAM: if (accept && last_pix) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt == DW'(CONV_LAT)) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the current state.
  always_comb begin
    busy      = (state != ST_IDLE);
    pix_ready = (state == ST_STREAM);
    done      = (state == ST_DONE);
  end

  // Frame counters, the weight load and the drain timer.
  // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      w_idx     <= '0;
      drain_cnt <= '0;
      for (int k = 0; k < N_TAPS; k++) wgt[k] <= '0;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DW'(1) : '0;
      case (state)
        ST_IDLE: if (start) begin
          row   <= '0;
          col   <= '0;
          w_idx <= '0;
        end
        ST_LOAD_W: if (w_valid) begin
          wgt[w_idx] <= w_data;
          w_idx      <= w_idx + 4'd1;
        end
        ST_STREAM: if (accept) begin
          if (col == CW'(IMG_W - 1)) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Window shift: columns move left, and the new column is {top row, middle row, incoming pixel}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win[i][j] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb_top;
      win[1][2] <= lb_mid;
      win[2][2] <= pix_data;
    end
  end

  // Valid/tag shift register. It advances every cycle so results in flight are not held up by pixel gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld <= '0;
      for (int i = 0; i <= CONV_LAT; i++) begin
        tag_row[i] <= '0;
        tag_col[i] <= '0;
      end
    end else begin
      tag_vld[0] <= accept && win_ok;
      tag_row[0] <= (accept && win_ok) ? row - RW'(2) : '0;
      tag_col[0] <= (accept && win_ok) ? col - CW'(2) : '0;
      for (int i = 1; i <= CONV_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_row[i] <= tag_row[i-1];
        tag_col[i] <= tag_col[i-1];
      end
    end
  end

  assign {a00, a01, a02} = {win[0][0], win[0][1], win[0][2]};
  assign {a10, a11, a12} = {win[1][0], win[1][1], win[1][2]};
  assign {a20, a21, a22} = {win[2][0], win[2][1], win[2][2]};

  assign {b00, b01, b02} = {wgt[B00], wgt[B01], wgt[B02]};
  assign {b10, b11, b12} = {wgt[B10], wgt[B11], wgt[B12]};
  assign {b20, b21, b22} = {wgt[B20], wgt[B21], wgt[B22]};

  // conv_out is already aligned with the last tag stage. Gating it holds the
  // result bus at zero between results and during reset.
  assign res_valid = tag_vld[CONV_LAT];
  assign res_row   = tag_row[CONV_LAT];
  assign res_col   = tag_col[CONV_LAT];
  assign res_data  = tag_vld[CONV_LAT] ? conv_out : '0;

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched on a 4x4 image with a 2-cycle
// 9-term dot-product model of conv_unit.
module tb_conv_window_sched;

  localparam int W  = 9;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int CL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, w_valid = 1'b0, pix_valid = 1'b0;
  logic [W-1:0] w_data = '0, pix_data = '0;
  logic pix_ready, res_valid, busy, done;
  logic [W-1:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
  logic [W-1:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;
  logic [2*W-1:0] conv_out, res_data, dot, s1;
  logic [1:0] res_row, res_col;

  int tests = 0, fails = 0, cyc = 0;
  int res_n = 0, acc_n = 0, done_cyc = -1;
  int r_data[16], r_row[16], r_col[16], r_cyc[16];
  int acc_cyc[16];
  int wts[9];
  bit fin;

  conv_window_sched #(.WIDTH(W), .IMG_W(IW), .IMG_H(IH), .CONV_LAT(CL)) dut (
    .clk(clk), .rst(rst), .start(start), .w_valid(w_valid), .w_data(w_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .a00(a00), .a01(a01), .a02(a02), .a10(a10), .a11(a11), .a12(a12),
    .a20(a20), .a21(a21), .a22(a22),
    .b00(b00), .b01(b01), .b02(b02), .b10(b10), .b11(b11), .b12(b12),
    .b20(b20), .b21(b21), .b22(b22),
    .conv_out(conv_out), .res_valid(res_valid), .res_data(res_data),
    .res_row(res_row), .res_col(res_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // conv_unit model: dot product registered twice (latency 2).
  logic [W-1:0] av[9], bv[9];
  assign av = '{a00, a01, a02, a10, a11, a12, a20, a21, a22};
  assign bv = '{b00, b01, b02, b10, b11, b12, b20, b21, b22};
  always_comb begin
    dot = '0;
    for (int k = 0; k < 9; k++) dot = dot + {{W{1'b0}}, av[k]} * {{W{1'b0}}, bv[k]};
  end
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      conv_out <= '0;
    end else begin
      s1       <= dot;
      conv_out <= s1;
    end
  end

  // Record accepts, results and done, away from the active edge.
  always @(negedge clk) begin
    if (pix_valid && pix_ready && acc_n < 16) begin
      acc_cyc[acc_n] = cyc;
      acc_n++;
    end
    if (res_valid && res_n < 16) begin
      r_data[res_n] = int'(res_data);
      r_row[res_n]  = int'(res_row);
      r_col[res_n]  = int'(res_col);
      r_cyc[res_n]  = cyc;
      res_n++;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    res_n    = 0;
    acc_n    = 0;
    done_cyc = -1;
  endtask

  // One frame: start, nine weights, sixteen pixels, then wait for done.
  // A non-negative stop_after abandons the frame once that many pixels have been accepted.
  task automatic run_frame(input bit gaps, input bit pix_in_load, input bit start_mid,
                           input int stop_after, output bit finished);
    int p, guard;
    bit acc;
    clear_log();
    finished = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    for (int k = 0; k < 9; k++) begin
      w_valid = 1'b1;
      w_data  = W'(wts[k]);
      if (pix_in_load) begin
        pix_valid = 1'b1;
        pix_data  = W'(99);
      end
      if (pix_in_load && k == 4) check("pix_ready_in_load", int'(pix_ready), 0);
      tick();
    end
    w_valid   = 1'b0;
    pix_valid = 1'b0;
    check("b00_loaded", int'(b00), wts[0]);
    check("b11_loaded", int'(b11), wts[4]);
    check("b22_loaded", int'(b22), wts[8]);
    if (pix_in_load) check("no_pix_in_load", acc_n, 0);
    p = 0;
    guard = 0;
    while (p < 16 && guard < 400) begin
      if (stop_after >= 0 && p == stop_after) begin
        pix_valid = 1'b0;
        start     = 1'b0;
        return;
      end
      pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data  = W'(p);
      start     = start_mid && (p == 5);
      acc       = pix_valid && pix_ready;
      tick();
      if (acc) p++;
      guard++;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
    if (p < 16) check("stream_timeout", p, 16);
    guard = 0;
    while (done_cyc < 0 && guard < 50) begin
      tick();
      guard++;
    end
    check("done_seen", int'(done_cyc >= 0), 1);
    tick();
    check("idle_after_done", int'(busy), 0);
    finished = 1'b1;
  endtask

  // Compare the four logged results in raster order, their latency from the
  // accept of their bottom-right pixel, and the done timing.
  task automatic check_results(input string name, input int exp[4]);
    int idx;
    check($sformatf("%s_count", name), res_n, 4);
    for (int k = 0; k < 4 && k < res_n; k++) begin
      idx = (k / 2 + 2) * IW + (k % 2 + 2);
      check($sformatf("%s_data%0d", name, k), r_data[k], exp[k]);
      check($sformatf("%s_row%0d", name, k), r_row[k], k / 2);
      check($sformatf("%s_col%0d", name, k), r_col[k], k % 2);
      check($sformatf("%s_lat%0d", name, k), r_cyc[k] - acc_cyc[idx], 1 + CL);
    end
    if (acc_n == 16 && done_cyc >= 0)
      check($sformatf("%s_done_lat", name), done_cyc - acc_cyc[15], 1 + CL + 1);
  endtask

  initial begin
    #1;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_pix_ready", int'(pix_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_a00", int'(a00), 0);
    check("rst_b22", int'(b22), 0);
    check("rst_res_data", int'(res_data), 0);
    check("rst_res_row", int'(res_row), 0);
    rst = 1'b0;
    tick();

    // 1: all-ones kernel.
    wts = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_frame(1'b0, 1'b0, 1'b0, -1, fin);
    check_results("t1", '{45, 54, 81, 90});

    // 2: centre tap only.
    wts = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    run_frame(1'b0, 1'b0, 1'b0, -1, fin);
    check_results("t2", '{5, 6, 9, 10});

    // 3: all-ones kernel with random pixel gaps.
    wts = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_frame(1'b1, 1'b0, 1'b0, -1, fin);
    check_results("t3", '{45, 54, 81, 90});

    // 4: pixels offered during LOAD_W, start pulsed during STREAM.
    run_frame(1'b0, 1'b1, 1'b1, -1, fin);
    check_results("t4", '{45, 54, 81, 90});

    // 5: reset after pixel 9, then a clean frame.
    wts = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    run_frame(1'b0, 1'b0, 1'b0, 10, fin);
    check("t5_aborted", int'(fin), 0);
    check("t5_a22_before_rst", int'(a22), 9);
    rst = 1'b1;
    #1;
    check("t5_busy", int'(busy), 0);
    check("t5_pix_ready", int'(pix_ready), 0);
    check("t5_a22", int'(a22), 0);
    check("t5_b11", int'(b11), 0);
    check("t5_res_valid", int'(res_valid), 0);
    check("t5_res_data", int'(res_data), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    run_frame(1'b0, 1'b0, 1'b0, -1, fin);
    check_results("t5", '{5, 6, 9, 10});

    // 6: two frames back to back with different kernels.
    wts = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_frame(1'b0, 1'b0, 1'b0, -1, fin);
    check_results("t6a", '{45, 54, 81, 90});
    wts = '{2, 0, 0, 0, 0, 0, 0, 0, 1};
    run_frame(1'b0, 1'b0, 1'b0, -1, fin);
    check_results("t6b", '{10, 13, 22, 25});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
